// File: rtl/wb_regfile.sv
// Write-back register file: GPRs plus HI/LO with same-cycle write-to-read bypass,
// two combinational read ports and a write-back event counter.
module wb_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wb_wd,
   input  logic              wb_wreg,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   input  logic              wb_whilo,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  wb_cnt
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;

   // GPR storage; register 0 is never written so it stays zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_wreg && (wb_wd != '0)) begin
         regs[wb_wd] <= wb_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (wb_whilo) begin
         hi_q <= wb_hi;
         lo_q <= wb_lo;
      end
   end

   // Clear beats increment; discarded r0 writes still count as events
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_cnt <= '0;
      end else if (cnt_clr) begin
         wb_cnt <= '0;
      end else if (wb_wreg || wb_whilo) begin
         wb_cnt <= wb_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      rdata1 = '0;
      if (rst && re1 && (raddr1 != '0)) begin
         if (wb_wreg && (wb_wd == raddr1)) begin
            rdata1 = wb_wdata;
         end else begin
            rdata1 = regs[raddr1];
         end
      end
   end

   always_comb begin
      rdata2 = '0;
      if (rst && re2 && (raddr2 != '0)) begin
         if (wb_wreg && (wb_wd == raddr2)) begin
            rdata2 = wb_wdata;
         end else begin
            rdata2 = regs[raddr2];
         end
      end
   end

   // HI/LO bypass from the pending write-back
   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (rst) begin
         hi_o = wb_whilo ? wb_hi : hi_q;
         lo_o = wb_whilo ? wb_lo : lo_q;
      end
   end

endmodule
